// File: rtl/program_memory_controller_if.sv
// program_memory_controller_if: fetcher-side and memory-side read signals of the program-memory controller
interface program_memory_controller_if #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
);
  logic [NUM_CONSUMERS-1:0] consumer_read_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0] consumer_read_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
  logic mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  modport master (
    input consumer_read_valid, consumer_read_address, mem_read_ready, mem_read_data,
    output consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address
  );
  modport slave (
    output consumer_read_valid, consumer_read_address, mem_read_ready, mem_read_data,
    input consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address
  );
endinterface

// File: rtl/program_memory_controller.sv
// program_memory_controller: round-robin arbitration of fetcher reads onto one program-memory read port
module program_memory_controller #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
) (
  input logic clk,
  input logic reset,
  program_memory_controller_if.master bus
);
  localparam int IW = NUM_CONSUMERS > 1 ? $clog2(NUM_CONSUMERS) : 1;
  typedef enum logic [1:0] {IDLE, READ_WAITING, RELAYING} state_t;
  state_t state, state_n;
  logic [IW-1:0] grant, last_served, pick;
  logic any_req, take, finish, release_rdy;
  logic [ADDR_BITS-1:0] addr [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] data_q [NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0] ready_q;
  logic mem_valid_q;
  logic [ADDR_BITS-1:0] mem_addr_q;
  for (genvar i = 0; i < NUM_CONSUMERS; i++) begin : g_slice
    assign addr[i] = bus.consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
    assign bus.consumer_read_data[i*DATA_BITS +: DATA_BITS] = data_q[i];
  end
  assign bus.consumer_read_ready = ready_q;
  assign bus.mem_read_valid = mem_valid_q;
  assign bus.mem_read_address = mem_addr_q;
  // pick the first requester after last_served in rotation order; smallest offset wins
  always_comb begin
    any_req = 1'b0;
    pick = last_served;
    for (int k = NUM_CONSUMERS; k >= 1; k--)
      if (bus.consumer_read_valid[(int'(last_served) + k) % NUM_CONSUMERS]) begin
        any_req = 1'b1;
        pick = IW'((int'(last_served) + k) % NUM_CONSUMERS);
      end
  end
  // transaction sequencing: grant, wait for memory, relay until the fetcher lets go
  always_comb begin
    take = state == IDLE && any_req;
    finish = state == READ_WAITING && bus.mem_read_ready;
    release_rdy = state == RELAYING && !bus.consumer_read_valid[grant];
    state_n = take ? READ_WAITING
            : finish ? (bus.consumer_read_valid[grant] ? RELAYING : IDLE)
            : release_rdy ? IDLE
            : state;
  end
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // grant bookkeeping, memory request and per-fetcher returned data
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      grant <= '0;
      last_served <= IW'(NUM_CONSUMERS - 1);
      mem_valid_q <= 1'b0;
      mem_addr_q <= '0;
      ready_q <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) data_q[i] <= '0;
    end else begin
      if (take) begin
        grant <= pick;
        last_served <= pick;
        mem_addr_q <= addr[pick];
        mem_valid_q <= 1'b1;
      end
      if (finish) begin
        mem_valid_q <= 1'b0;
        if (bus.consumer_read_valid[grant]) begin
          data_q[grant] <= bus.mem_read_data;
          ready_q[grant] <= 1'b1;
        end
      end
      if (release_rdy) ready_q <= '0;
    end
endmodule

// File: tb/tb_program_memory_controller.sv
// tb_program_memory_controller: randomized fetchers and memory checked against a transaction-level round-robin model
module tb_program_memory_controller;
  localparam int N = 4;
  localparam int A = 8;
  localparam int D = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  program_memory_controller_if #(.NUM_CONSUMERS(N), .ADDR_BITS(A), .DATA_BITS(D)) bus ();
  program_memory_controller #(.NUM_CONSUMERS(N), .ADDR_BITS(A), .DATA_BITS(D)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [N-1:0] req;
  logic [A-1:0] addr [N];
  logic [D-1:0] mem_arr [256];
  logic [D-1:0] shadow [N];
  logic mready;
  bit busy, delivered;
  int g, last, wait_cnt, hog;
  logic [A-1:0] g_addr;
  int served[$];
  int p_req, p_wd, wmin, wmax, p_spur;

  function automatic int rr_pick(int lst, logic [N-1:0] r);
    for (int k = 1; k <= N; k++) if (r[(lst + k) % N]) return (lst + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    busy = 0;
    delivered = 0;
    last = N - 1;
    for (int i = 0; i < N; i++) shadow[i] = '0;
  endtask

  task automatic knobs(int pr, int pw, int wl, int wh, int ps);
    p_req = pr; p_wd = pw; wmin = wl; wmax = wh; p_spur = ps;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) bus.consumer_read_address[i*A +: A] = addr[i];
    bus.consumer_read_valid = req;
    bus.mem_read_ready = mready;
    bus.mem_read_data = mready ? mem_arr[g_addr] : D'($urandom);
  endtask

  task automatic cycle();
    int p;
    logic [N-1:0] exp_rdy;
    logic [N*D-1:0] exp_data;
    @(negedge clk);
    if (busy) begin
      if (mready) begin
        busy = 0;
        if (req[g]) begin
          delivered = 1;
          shadow[g] = mem_arr[g_addr];
          served.push_back(g);
        end
      end
    end else if (delivered) begin
      if (!req[g]) delivered = 0;
    end else begin
      p = rr_pick(last, req);
      if (p >= 0) begin
        g = p;
        g_addr = addr[p];
        last = p;
        busy = 1;
        wait_cnt = $urandom_range(wmax, wmin);
      end
    end
    exp_rdy = '0;
    if (delivered) exp_rdy[g] = 1'b1;
    for (int i = 0; i < N; i++) exp_data[i*D +: D] = shadow[i];
    checks++;
    if (bus.mem_read_valid !== busy) begin
      failures++;
      $display("FAIL mem_valid t=%0t got=%b exp=%b", $time, bus.mem_read_valid, busy);
    end
    if (busy) begin
      checks++;
      if (bus.mem_read_address !== g_addr) begin
        failures++;
        $display("FAIL mem_addr t=%0t got=%h exp=%h", $time, bus.mem_read_address, g_addr);
      end
    end
    checks++;
    if (bus.consumer_read_ready !== exp_rdy) begin
      failures++;
      $display("FAIL ready t=%0t got=%b exp=%b", $time, bus.consumer_read_ready, exp_rdy);
    end
    checks++;
    if (bus.consumer_read_data !== exp_data) begin
      failures++;
      $display("FAIL data t=%0t got=%h exp=%h", $time, bus.consumer_read_data, exp_data);
    end
    checks++;
    if ($countones(bus.consumer_read_ready) > 1) begin
      failures++;
      $display("FAIL onehot t=%0t got=%b exp=at_most_one", $time, bus.consumer_read_ready);
    end
    for (int i = 0; i < N; i++) begin
      if (bus.consumer_read_ready[i] && req[i]) req[i] = 1'b0;
      else if (i == hog && !req[i]) req[i] = 1'b1;
      else if (busy && i == g && req[i] && $urandom_range(99, 0) < p_wd) req[i] = 1'b0;
      else if (!req[i] && $urandom_range(99, 0) < p_req) begin
        req[i] = 1'b1;
        addr[i] = A'($urandom);
      end
      if (busy && i == g) addr[i] = A'($urandom);
    end
    if (busy) begin
      mready = wait_cnt == 0;
      if (wait_cnt > 0) wait_cnt--;
    end else mready = $urandom_range(99, 0) < p_spur;
    drive();
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req = '0;
    mready = 1'b0;
    model_reset();
    drive();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus.mem_read_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mem_valid got=%b exp=0", bus.mem_read_valid);
    end
    checks++;
    if (bus.mem_read_address !== '0) begin
      failures++;
      $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_read_address);
    end
    checks++;
    if (bus.consumer_read_ready !== '0) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=0", bus.consumer_read_ready);
    end
    checks++;
    if (bus.consumer_read_data !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", bus.consumer_read_data);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    int n0;
    knobs(0, 0, 0, 0, 0);
    mem_arr[8'h1A] = 16'hBEEF;
    n0 = served.size();
    req[2] = 1'b1;
    addr[2] = 8'h1A;
    drive();
    run(8);
    checks++;
    if (served.size() != n0 + 1 || served[n0] != 2) begin
      failures++;
      $display("FAIL single_served got=%0d exp=1", served.size() - n0);
    end
    checks++;
    if (bus.consumer_read_data[2*D +: D] !== 16'hBEEF) begin
      failures++;
      $display("FAIL single_data got=%h exp=beef", bus.consumer_read_data[2*D +: D]);
    end
  endtask

  task automatic test_contention();
    int n0;
    do_reset();
    knobs(0, 0, 0, 0, 0);
    n0 = served.size();
    for (int i = 0; i < N; i++) begin
      addr[i] = A'(8'h10 + i);
      mem_arr[8'h10 + i] = D'(16'h110 + i);
    end
    req = '1;
    drive();
    run(20);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (served.size() <= n0 + i || served[n0 + i] != i) begin
        failures++;
        $display("FAIL contention_order idx=%0d got=%0d exp=%0d", i,
                 served.size() > n0 + i ? served[n0 + i] : -1, i);
      end
      checks++;
      if (bus.consumer_read_data[i*D +: D] !== D'(16'h110 + i)) begin
        failures++;
        $display("FAIL contention_data idx=%0d got=%h exp=%h", i,
                 bus.consumer_read_data[i*D +: D], D'(16'h110 + i));
      end
    end
  endtask

  task automatic test_wait_states();
    int n0;
    knobs(0, 0, 5, 5, 0);
    n0 = served.size();
    req[1] = 1'b1;
    addr[1] = A'($urandom);
    drive();
    run(12);
    checks++;
    if (served.size() != n0 + 1 || served[n0] != 1) begin
      failures++;
      $display("FAIL wait_served got=%0d exp=1", served.size() - n0);
    end
  endtask

  task automatic test_withdraw();
    int n0;
    logic [D-1:0] prior;
    prior = shadow[1];
    knobs(0, 100, 2, 2, 0);
    mem_arr[8'h55] = (prior == 16'h1234) ? 16'h4321 : 16'h1234;
    n0 = served.size();
    req[1] = 1'b1;
    addr[1] = 8'h55;
    drive();
    run(5);
    knobs(0, 0, 0, 0, 0);
    req[3] = 1'b1;
    addr[3] = A'($urandom);
    drive();
    run(6);
    checks++;
    if (bus.consumer_read_data[1*D +: D] !== prior) begin
      failures++;
      $display("FAIL withdraw_data got=%h exp=%h", bus.consumer_read_data[1*D +: D], prior);
    end
    checks++;
    if (served.size() != n0 + 1 || served[n0] != 3) begin
      failures++;
      $display("FAIL withdraw_next got=%0d exp=1", served.size() - n0);
    end
  endtask

  task automatic test_async_reset();
    int n0;
    knobs(0, 0, 6, 6, 0);
    req[2] = 1'b1;
    addr[2] = A'($urandom);
    drive();
    run(3);
    checks++;
    if (bus.mem_read_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_valid got=%b exp=1", bus.mem_read_valid);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.mem_read_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_mem_valid got=%b exp=0", bus.mem_read_valid);
    end
    checks++;
    if (bus.consumer_read_ready !== '0) begin
      failures++;
      $display("FAIL async_ready got=%b exp=0", bus.consumer_read_ready);
    end
    model_reset();
    knobs(0, 0, 0, 0, 0);
    req = '1;
    mready = 1'b0;
    drive();
    @(negedge clk);
    reset = 1'b1;
    n0 = served.size();
    run(4);
    checks++;
    if (served.size() <= n0 || served[n0] != 0) begin
      failures++;
      $display("FAIL async_first_grant got=%0d exp=0", served.size() > n0 ? served[n0] : -1);
    end
    run(20);
  endtask

  task automatic test_fairness();
    int n0, pos;
    knobs(0, 0, 0, 1, 0);
    hog = 0;
    req[0] = 1'b1;
    addr[0] = A'($urandom);
    drive();
    run(3);
    req[3] = 1'b1;
    addr[3] = A'($urandom);
    drive();
    n0 = served.size();
    run(15);
    hog = -1;
    pos = -1;
    for (int j = n0; j < served.size(); j++) if (served[j] == 3 && pos < 0) pos = j - n0;
    checks++;
    if (pos < 0 || pos > 1) begin
      failures++;
      $display("FAIL fairness_position got=%0d exp=0..1", pos);
    end
    run(10);
  endtask

  task automatic test_random();
    int n0;
    knobs(40, 10, 0, 3, 20);
    n0 = served.size();
    run(400);
    knobs(0, 0, 0, 0, 0);
    run(40);
    checks++;
    if (served.size() - n0 < 20) begin
      failures++;
      $display("FAIL random_throughput got=%0d exp=>=20", served.size() - n0);
    end
  endtask

  initial begin
    hog = -1;
    g = 0;
    g_addr = '0;
    wait_cnt = 0;
    req = '0;
    mready = 1'b0;
    for (int i = 0; i < N; i++) addr[i] = '0;
    for (int i = 0; i < 256; i++) mem_arr[i] = D'($urandom);
    model_reset();
    knobs(0, 0, 0, 0, 0);
    drive();
    test_reset();
    test_single();
    test_contention();
    test_wait_states();
    test_withdraw();
    test_async_reset();
    test_fairness();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/program_memory_controller.md
Name: program_memory_controller

Overview:
- Arbitrates program-memory reads from NUM_CONSUMERS per-core fetchers onto one shared read port of external program memory.
- Each fetcher holds a request until it sees ready, then takes the instruction word. The controller relays the request and address to memory, and returns the data and a ready to the requesting fetcher.
- Placed directly upstream of the fetchers, between them and program memory. Round-robin fairness.

Parameters:
- NUM_CONSUMERS, 4, number of fetchers served (≥1)
- ADDR_BITS, 8, program address width
- DATA_BITS, 16, instruction word width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset; clears all state immediately when low
- consumer_read_valid  in  NUM_CONSUMERS  per-fetcher read request, level, held until served
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed addresses; consumer i at [i*ADDR_BITS +: ADDR_BITS]
- consumer_read_ready  out  NUM_CONSUMERS  per-fetcher data-valid indication
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed per-fetcher returned words
- mem_read_valid  out  1  request to program memory
- mem_read_address  out  ADDR_BITS  address to program memory
- mem_read_ready  in  1  memory response strobe, data valid this cycle
- mem_read_data  in  DATA_BITS  memory read data

Behaviour:
- Reset (reset low, async):
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer last_served = NUM_CONSUMERS-1, so consumer 0 wins first.
- FSM states are IDLE, READ_WAITING and RELAYING. One transaction is in flight at a time.
- IDLE:
  - At an edge, if any consumer_read_valid bit is set, grant the first set bit scanning last_served+1, +2, … modulo NUM_CONSUMERS.
  - On grant: latch grant id; mem_read_address <= that consumer's address; mem_read_valid <= 1; last_served <= grant id; go READ_WAITING.
  - No request: stay IDLE, outputs unchanged.
- READ_WAITING:
  - mem_read_valid and mem_read_address are held stable until mem_read_ready is sampled 1.
  - On mem_read_ready:
    - mem_read_valid <= 0.
    - Granted consumer's data slice <= mem_read_data.
    - consumer_read_ready[grant] <= 1.
    - Go RELAYING.
- RELAYING:
  - consumer_read_ready[grant] stays 1 while consumer_read_valid[grant] is sampled 1.
  - At the first edge it is sampled 0: ready <= 0, go IDLE.
  - New arbitration happens at the following edge at the earliest.
- Latency: grant edge to mem_read_valid high is 1 cycle. mem_read_ready edge to consumer_read_ready high is 1 cycle. Minimum request-to-ready is 2 edges with zero-wait memory.
- consumer_read_data slices hold their last value until that consumer is served again. Non-granted slices are never modified.
- At most one consumer_read_ready bit is high at any time.
- Address changes on consumer_read_address after grant are ignored for that transaction.
- Boundary rules:
  - Granted request withdrawn during READ_WAITING: the memory transaction still completes and its data is discarded. No ready is asserted and no data slice is updated. Go IDLE.
  - mem_read_ready in IDLE or RELAYING: ignored.
  - Simultaneous requests: exactly one is granted per round-robin. The others keep waiting and are served in rotation order in later transactions.
  - Single requester re-requesting: served again after its ready deasserts; no starvation of others, because the rotation starts after last_served.
  - NUM_CONSUMERS=1: the pointer is degenerate and consumer 0 is always granted.
  - Reset asserted mid-transaction: abandon immediately. mem_read_valid and all ready bits drop asynchronously. After reset release, the controller starts in IDLE with no memory of the transaction.

Test Plan:
- Single request, zero-wait memory: consumer 2 requests addr 0x1A, memory returns 0xBEEF on the cycle after valid. Required: mem_read_address=0x1A; consumer_read_ready[2] high with data slice 2 = 0xBEEF; ready drops the edge after consumer_read_valid[2] falls.
- Contention after reset: all 4 consumers request at once with addresses 0x10..0x13, memory returns address+0x100. Required: grants in order 0,1,2,3; each consumer receives 0x110..0x113; at most one ready bit high at any time.
- Wait states: memory holds mem_read_ready low for 5 cycles. Required: mem_read_valid and mem_read_address stay stable for all 5 cycles; consumer ready appears exactly 1 cycle after the ready strobe.
- Withdrawn request: consumer 1 drops its request during READ_WAITING, memory returns 0x1234. Required: no consumer_read_ready pulse; data slice 1 keeps its prior value; controller returns to IDLE and serves the next requester.
- Async reset mid-read: reset driven low while mem_read_valid=1 and between clock edges. Required: mem_read_valid and all ready bits go 0 without a clock edge. After release, the first request granted is consumer 0's.
- Fairness: consumer 0 requests continuously and consumer 3 requests once. Required: consumer 3 is served no later than the second transaction after its request.
